// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central stall/flush sequencer for the 5-stage RISC-V pipeline. Looks at the
// ID, EX and MEM stages and drives the write enables and flushes of the PC and
// the four pipeline registers. It resolves three kinds of hazard:
//   - load-use    : one bubble is inserted into ID/EX while PC and IF/ID hold
//   - redirect    : a taken branch (PCSrc, from EX/MEM) loads the PC target and
//                   flushes IF/ID, ID/EX and EX/MEM in the same cycle
//   - memory wait : the whole pipeline freezes while data memory is busy
// A watchdog counts consecutive busy MEM_WAIT cycles. When the counter is
// saturated and memory is still busy, the FSM enters ERROR. ERROR is sticky
// and only rst leaves it.
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   Adds the perf_stall_cycles and perf_flushes saturating 32-bit counters.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   id_rs1/id_rs2            source registers of the instruction in ID
//   id_rs1_used/id_rs2_used  the ID instruction really reads rs1/rs2
//   ex_memRead               the EX instruction is a load
//   ex_regToWrite            destination register of the EX instruction
//   PCSrc                    taken branch resolved (registered in EX/MEM)
//   mem_memRead/mem_memWrite the MEM instruction accesses data memory
//   dmem_ready               data memory completes its access this cycle
//   pc_en .. mem_wb_en       stage register write enables
//   pc_sel_branch            the PC loads the branch target
//   if_id/id_ex/ex_mem_flush load a bubble (all control bits 0)
//   mem_timeout              sticky watchdog error
//   state                    FSM state for debug: RUN=0, MEM_WAIT=1, ERROR=2
//   perf_stall_cycles        (HAZARD_PERF_CNT_EN) freeze and bubble cycles
//   perf_flushes             (HAZARD_PERF_CNT_EN) redirect cycles
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int REG_NUM_BITWIDTH  = 5,
  parameter int WAIT_CNT_BITWIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [REG_NUM_BITWIDTH-1:0] id_rs1,
  input  logic [REG_NUM_BITWIDTH-1:0] id_rs2,
  input  logic                        id_rs1_used,
  input  logic                        id_rs2_used,
  input  logic                        ex_memRead,
  input  logic [REG_NUM_BITWIDTH-1:0] ex_regToWrite,
  input  logic                        PCSrc,
  input  logic                        mem_memRead,
  input  logic                        mem_memWrite,
  input  logic                        dmem_ready,
  output logic                        pc_en,
  output logic                        if_id_en,
  output logic                        id_ex_en,
  output logic                        ex_mem_en,
  output logic                        mem_wb_en,
  output logic                        pc_sel_branch,
  output logic                        if_id_flush,
  output logic                        id_ex_flush,
  output logic                        ex_mem_flush,
  output logic                        mem_timeout,
  output logic [1:0]                  state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]                 perf_stall_cycles,
  output logic [31:0]                 perf_flushes
`endif
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_e;

  localparam logic [WAIT_CNT_BITWIDTH-1:0] WAIT_MAX = '1;

  state_e                       state_q, state_d;
  logic [WAIT_CNT_BITWIDTH-1:0] wait_cnt_q, wait_cnt_d;
  logic                         timeout_q, timeout_d;

  logic mem_busy;
  logic load_use;

  assign mem_busy = (mem_memRead | mem_memWrite) & ~dmem_ready;

  // Register x0 is never a real dependency.
  assign load_use = ex_memRead & (ex_regToWrite != '0) &
                    ((id_rs1_used & (id_rs1 == ex_regToWrite)) |
                     (id_rs2_used & (id_rs2 == ex_regToWrite)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Next state. rst has priority in the register block above.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    case (state_q)
      ST_RUN: begin
        wait_cnt_d = '0;
        if (mem_busy) state_d = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        if (!mem_busy) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_MAX) begin
          // The counter never wraps; its terminal value ends the wait.
          state_d   = ST_ERROR;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Outputs: combinational from state_q and current inputs.
  // Priority: freeze > redirect > bubble > normal.
  always_comb begin
    pc_en         = 1'b0;
    if_id_en      = 1'b0;
    id_ex_en      = 1'b0;
    ex_mem_en     = 1'b0;
    mem_wb_en     = 1'b0;
    pc_sel_branch = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    if (!rst && (state_q == ST_RUN || state_q == ST_MEM_WAIT)) begin
      if (mem_busy) begin
        // Freeze: all enables and flushes stay 0.
      end else if (PCSrc) begin
        // The flush also discards the ID instruction, so a concurrent
        // load-use needs no bubble. MEM/WB keeps the branch retiring.
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        mem_wb_en     = 1'b1;
        pc_sel_branch = 1'b1;
        if_id_flush   = 1'b1;
        id_ex_flush   = 1'b1;
        ex_mem_flush  = 1'b1;
      end else if (load_use) begin
        // PC and IF/ID hold the consumer; ID/EX loads a bubble.
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        id_ex_flush = 1'b1;
      end else begin
        pc_en     = 1'b1;
        if_id_en  = 1'b1;
        id_ex_en  = 1'b1;
        ex_mem_en = 1'b1;
        mem_wb_en = 1'b1;
      end
    end
  end

  assign mem_timeout = timeout_q;
  assign state       = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic active;
  logic stall_cyc;
  logic redirect_cyc;

  assign active       = ~rst & (state_q == ST_RUN || state_q == ST_MEM_WAIT);
  assign stall_cyc    = active & (mem_busy | (~PCSrc & load_use));
  assign redirect_cyc = active & ~mem_busy & PCSrc;

  logic [31:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall_cyc && perf_stall_q != 32'hFFFF_FFFF)
        perf_stall_q <= perf_stall_q + 32'd1;
      if (redirect_cyc && perf_flush_q != 32'hFFFF_FFFF)
        perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flushes      = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Directed bench for pipeline_hazard_ctrl. Inputs change on the falling clock
// edge; outputs are sampled 1 ns later, well away from the rising edge. The
// ten control outputs are viewed as one packed word:
//   {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
//    pc_sel_branch, if_id_flush, id_ex_flush, ex_mem_flush, mem_timeout}
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam logic [9:0] O_OFF    = 10'b00000_0_000_0;
  localparam logic [9:0] O_NORMAL = 10'b11111_0_000_0;
  localparam logic [9:0] O_FREEZE = 10'b00000_0_000_0;
  localparam logic [9:0] O_REDIR  = 10'b11111_1_111_0;
  localparam logic [9:0] O_BUBBLE = 10'b00111_0_010_0;
  localparam logic [9:0] O_ERROR  = 10'b00000_0_000_1;

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_regToWrite;
  logic       id_rs1_used, id_rs2_used, ex_memRead, PCSrc;
  logic       mem_memRead, mem_memWrite, dmem_ready;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic       pc_sel_branch, if_id_flush, id_ex_flush, ex_mem_flush;
  logic       mem_timeout;
  logic [1:0] state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_flushes;
`endif

  logic [9:0] outs;
  assign outs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                 pc_sel_branch, if_id_flush, id_ex_flush, ex_mem_flush, mem_timeout};

  int checks = 0;
  int fails  = 0;

  pipeline_hazard_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_rs1_used   (id_rs1_used),
    .id_rs2_used   (id_rs2_used),
    .ex_memRead    (ex_memRead),
    .ex_regToWrite (ex_regToWrite),
    .PCSrc         (PCSrc),
    .mem_memRead   (mem_memRead),
    .mem_memWrite  (mem_memWrite),
    .dmem_ready    (dmem_ready),
    .pc_en         (pc_en),
    .if_id_en      (if_id_en),
    .id_ex_en      (id_ex_en),
    .ex_mem_en     (ex_mem_en),
    .mem_wb_en     (mem_wb_en),
    .pc_sel_branch (pc_sel_branch),
    .if_id_flush   (if_id_flush),
    .id_ex_flush   (id_ex_flush),
    .ex_mem_flush  (ex_mem_flush),
    .mem_timeout   (mem_timeout),
    .state         (state)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flushes      (perf_flushes)
`endif
  );

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_regToWrite = 5'd0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_memRead = 1'b0; PCSrc = 1'b0;
    mem_memRead = 1'b0; mem_memWrite = 1'b0; dmem_ready = 1'b1;
  endtask

  // Advance one rising edge; return at the next falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1,
                              input logic rs1_used);
    ex_memRead = 1'b1; ex_regToWrite = rd; id_rs1 = rs1; id_rs1_used = rs1_used;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step(); step();
    #1;
    checks++;
    if (outs !== O_OFF) begin
      fails++; $display("FAIL reset_outs: got %b expected %b", outs, O_OFF);
    end
    checks++;
    if (state !== S_RUN) begin
      fails++; $display("FAIL reset_state: got %0d expected %0d", state, S_RUN);
    end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (outs !== O_NORMAL) begin
      fails++; $display("FAIL after_reset_normal: got %b expected %b", outs, O_NORMAL);
    end
  endtask

  task automatic test_load_use();
    step();
    set_load_use(5'd5, 5'd5, 1'b1);
    #1;
    checks++;
    if (outs !== O_BUBBLE) begin
      fails++; $display("FAIL load_use_bubble: got %b expected %b", outs, O_BUBBLE);
    end
    step();
    // Bubble now in EX: no longer a load.
    ex_memRead = 1'b0;
    #1;
    checks++;
    if (outs !== O_NORMAL) begin
      fails++; $display("FAIL load_use_next_normal: got %b expected %b", outs, O_NORMAL);
    end
    // rs2 dependency also triggers a bubble.
    step();
    idle_inputs();
    ex_memRead = 1'b1; ex_regToWrite = 5'd17; id_rs2 = 5'd17; id_rs2_used = 1'b1;
    id_rs1 = 5'd3; id_rs1_used = 1'b1;
    #1;
    checks++;
    if (outs !== O_BUBBLE) begin
      fails++; $display("FAIL load_use_rs2: got %b expected %b", outs, O_BUBBLE);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_no_bubble();
    step();
    set_load_use(5'd0, 5'd0, 1'b1);
    #1;
    checks++;
    if (outs !== O_NORMAL) begin
      fails++; $display("FAIL no_bubble_x0: got %b expected %b", outs, O_NORMAL);
    end
    step();
    set_load_use(5'd5, 5'd5, 1'b0);
    #1;
    checks++;
    if (outs !== O_NORMAL) begin
      fails++; $display("FAIL no_bubble_unused: got %b expected %b", outs, O_NORMAL);
    end
    step();
    set_load_use(5'd5, 5'd6, 1'b1);
    #1;
    checks++;
    if (outs !== O_NORMAL) begin
      fails++; $display("FAIL no_bubble_diff_reg: got %b expected %b", outs, O_NORMAL);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_redirect();
    step();
    set_load_use(5'd9, 5'd9, 1'b1);
    PCSrc = 1'b1;
    #1;
    checks++;
    if (outs !== O_REDIR) begin
      fails++; $display("FAIL redirect_over_load_use: got %b expected %b", outs, O_REDIR);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (state !== S_RUN) begin
      fails++; $display("FAIL redirect_state: got %0d expected %0d", state, S_RUN);
    end
  endtask

  task automatic test_mem_wait();
    // Single-cycle memory costs nothing.
    step();
    mem_memRead = 1'b1; dmem_ready = 1'b1;
    #1;
    checks++;
    if (outs !== O_NORMAL) begin
      fails++; $display("FAIL mem_ready_normal: got %b expected %b", outs, O_NORMAL);
    end
    // Three busy cycles, with PCSrc and a load-use hidden under the freeze.
    step();
    dmem_ready = 1'b0; PCSrc = 1'b1;
    set_load_use(5'd4, 5'd4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (outs !== O_FREEZE) begin
        fails++; $display("FAIL mem_wait_freeze[%0d]: got %b expected %b", i, outs, O_FREEZE);
      end
      checks++;
      if (state !== (i == 0 ? S_RUN : S_WAIT)) begin
        fails++; $display("FAIL mem_wait_state[%0d]: got %0d expected %0d", i, state,
                          (i == 0 ? S_RUN : S_WAIT));
      end
      step();
    end
    // Completion cycle: priority rules apply normally (redirect wins).
    dmem_ready = 1'b1;
    #1;
    checks++;
    if (outs !== O_REDIR || state !== S_WAIT) begin
      fails++; $display("FAIL mem_wait_complete: got %b/%0d expected %b/%0d",
                        outs, state, O_REDIR, S_WAIT);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (state !== S_RUN) begin
      fails++; $display("FAIL mem_wait_back_run: got %0d expected %0d", state, S_RUN);
    end
  endtask

  task automatic test_watchdog();
    step();
    mem_memWrite = 1'b1; dmem_ready = 1'b0;
    #1;
    checks++;
    if (state !== S_RUN) begin
      fails++; $display("FAIL wd_start_state: got %0d expected %0d", state, S_RUN);
    end
    // 256 busy MEM_WAIT cycles follow the busy RUN cycle.
    for (int i = 1; i <= 256; i++) begin
      step();
      #1;
      checks++;
      if (state !== S_WAIT || outs !== O_FREEZE) begin
        fails++; $display("FAIL wd_wait[%0d]: got %0d/%b expected %0d/%b",
                          i, state, outs, S_WAIT, O_FREEZE);
      end
    end
    step();
    #1;
    checks++;
    if (state !== S_ERR || outs !== O_ERROR) begin
      fails++; $display("FAIL wd_error: got %0d/%b expected %0d/%b", state, outs, S_ERR, O_ERROR);
    end
    // ERROR is sticky even after memory recovers.
    idle_inputs();
    step(); step();
    #1;
    checks++;
    if (state !== S_ERR || outs !== O_ERROR) begin
      fails++; $display("FAIL wd_sticky: got %0d/%b expected %0d/%b", state, outs, S_ERR, O_ERROR);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({outs[9:1]} !== 9'b0) begin
      fails++; $display("FAIL wd_rst_outs: got %b expected enables/flushes 0", outs);
    end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (state !== S_RUN || mem_timeout !== 1'b0 || outs !== O_NORMAL) begin
      fails++; $display("FAIL wd_after_rst: got %0d/%b expected %0d/%b",
                        state, outs, S_RUN, O_NORMAL);
    end
  endtask

  task automatic test_back_to_back();
    // Two consecutive load-use cycles (a second dependent load chain).
    step();
    set_load_use(5'd7, 5'd7, 1'b1);
    #1;
    checks++;
    if (outs !== O_BUBBLE) begin
      fails++; $display("FAIL b2b_bubble0: got %b expected %b", outs, O_BUBBLE);
    end
    step();
    set_load_use(5'd8, 5'd8, 1'b1);
    #1;
    checks++;
    if (outs !== O_BUBBLE) begin
      fails++; $display("FAIL b2b_bubble1: got %b expected %b", outs, O_BUBBLE);
    end
    step();
    idle_inputs();
    PCSrc = 1'b1;
    #1;
    checks++;
    if (outs !== O_REDIR) begin
      fails++; $display("FAIL b2b_redirect: got %b expected %b", outs, O_REDIR);
    end
    step();
    idle_inputs();
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (perf_stall_cycles !== 32'd0 || perf_flushes !== 32'd0) begin
      fails++; $display("FAIL perf_reset: got %0d/%0d expected 0/0", perf_stall_cycles, perf_flushes);
    end
    step();
    set_load_use(5'd5, 5'd5, 1'b1);   step();
    idle_inputs();                    step();
    set_load_use(5'd6, 5'd6, 1'b1);   step();
    idle_inputs(); PCSrc = 1'b1;      step();
    idle_inputs(); mem_memRead = 1'b1; dmem_ready = 1'b0;
    step(); step(); step();
    dmem_ready = 1'b1;                step();
    idle_inputs();                    step();
    #1;
    checks++;
    if (perf_stall_cycles !== 32'd5) begin
      fails++; $display("FAIL perf_stall: got %0d expected 5", perf_stall_cycles);
    end
    checks++;
    if (perf_flushes !== 32'd1) begin
      fails++; $display("FAIL perf_flushes: got %0d expected 1", perf_flushes);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    idle_inputs();
    step();
    test_reset();
    test_load_use();
    test_no_bubble();
    test_redirect();
    test_mem_wait();
    test_back_to_back();
    test_watchdog();
`ifdef HAZARD_PERF_CNT_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
